jpeg_bitstream_unpacker: RTL

//  Reader side of the JPEG entropy-coded byte stream that the encoder pipeline writes.

---
 rtl/jpeg_bitstream_unpacker_if.sv | 26 ++
 rtl/jpeg_bitstream_unpacker.sv | 114 +++++++++++
 2 files changed

// File: rtl/jpeg_bitstream_unpacker_if.sv
// Byte-in / bit-window-out bus of the JPEG bitstream unpacker.
interface jpeg_bitstream_unpacker_if;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic [15:0] win_data;
    logic [5:0]  bits_avail;
    logic        consume_en;
    logic [4:0]  consume_len;
    logic        marker_found;
    logic [7:0]  marker_code;
    logic        marker_ack;
    logic        underflow_err;

    // Byte source and bit consumer side (Huffman decoder / testbench).
    modport master (
        output in_valid, in_byte, consume_en, consume_len, marker_ack,
        input  in_ready, win_data, bits_avail, marker_found, marker_code, underflow_err
    );

    // Unpacker side.
    modport slave (
        input  in_valid, in_byte, consume_en, consume_len, marker_ack,
        output in_ready, win_data, bits_avail, marker_found, marker_code, underflow_err
    );
endinterface

// File: rtl/jpeg_bitstream_unpacker.sv
// JPEG entropy-coded stream reader: removes 0xFF00 stuffing, skips 0xFF fill
// bytes, halts on markers and offers a 16-bit MSB-aligned bit window.
module jpeg_bitstream_unpacker (
    input logic                        clock,
    input logic                        reset,
    jpeg_bitstream_unpacker_if.slave   bus
);
    localparam int unsigned BUF_W    = 32;
    localparam int unsigned WIN_W    = 16;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned FILL_MAX = BUF_W - BYTE_W;

    typedef enum logic [1:0] {
        S_DATA   = 2'd0,
        S_FF     = 2'd1,
        S_MARKER = 2'd2
    } state_t;

    state_t             state;
    logic [BUF_W-1:0]   buf_q;
    logic [CNT_W-1:0]   avail_q;
    logic               marker_found_q;
    logic [BYTE_W-1:0]  marker_code_q;
    logic               underflow_q;

    logic               accept;
    logic               consume_bad;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   base;
    logic               do_append;
    logic [BYTE_W-1:0]  append_val;
    logic [BUF_W-1:0]   next_buf;
    logic [CNT_W-1:0]   next_avail;

    // in_ready looks only at state and the pre-consume fill level.
    assign bus.in_ready      = (state != S_MARKER) && (avail_q <= CNT_W'(FILL_MAX));
    assign bus.win_data      = buf_q[BUF_W-1 -: WIN_W];
    assign bus.bits_avail    = avail_q;
    assign bus.marker_found  = marker_found_q;
    assign bus.marker_code   = marker_code_q;
    assign bus.underflow_err = underflow_q;

    // Next buffer contents: legal consume shifts the head out, then an appended byte lands just after the remaining bits.
    always_comb begin
        accept      = bus.in_valid && bus.in_ready;
        consume_bad = bus.consume_en &&
                      ((bus.consume_len == 5'd0) ||
                       (bus.consume_len > 5'(WIN_W)) ||
                       (CNT_W'(bus.consume_len) > avail_q));
        cnt         = (bus.consume_en && !consume_bad) ? CNT_W'(bus.consume_len) : '0;
        base        = avail_q - cnt;
        do_append   = accept &&
                      (((state == S_DATA) && (bus.in_byte != 8'hFF)) ||
                       ((state == S_FF)   && (bus.in_byte == 8'h00)));
        append_val  = (state == S_FF) ? 8'hFF : bus.in_byte;
        next_buf    = buf_q << cnt;
        next_avail  = base;
        if (do_append) begin
            next_buf   = next_buf | ({append_val, {(BUF_W-BYTE_W){1'b0}}} >> base);
            next_avail = base + CNT_W'(BYTE_W);
        end
    end

    // Stuffing/marker FSM, bit buffer and status registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_DATA;
            buf_q          <= '0;
            avail_q        <= '0;
            marker_found_q <= 1'b0;
            marker_code_q  <= '0;
            underflow_q    <= 1'b0;
        end else begin
            if (consume_bad) begin
                underflow_q <= 1'b1;
            end

            buf_q   <= next_buf;
            avail_q <= next_avail;

            case (state)
                S_DATA: begin
                    if (accept && (bus.in_byte == 8'hFF)) begin
                        state <= S_FF;
                    end
                end
                S_FF: begin
                    if (accept) begin
                        if (bus.in_byte == 8'h00) begin
                            state <= S_DATA;
                        end else if (bus.in_byte != 8'hFF) begin
                            state          <= S_MARKER;
                            marker_found_q <= 1'b1;
                            marker_code_q  <= bus.in_byte;
                        end
                    end
                end
                S_MARKER: begin
                    // Leftover bits belong to the finished segment; drop them on resume.
                    if (bus.marker_ack) begin
                        state          <= S_DATA;
                        marker_found_q <= 1'b0;
                        buf_q          <= '0;
                        avail_q        <= '0;
                    end
                end
                default: begin
                    state <= S_DATA;
                end
            endcase
        end
    end
endmodule
